fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 99 +++++++++
 tb/tb_fetch_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem read feeding a 2-entry {instruction, pc+4} buffer.
// Redirects flush the buffer and refetch; a read overtaken by a redirect is dropped on return.
module fetch_stage #(
    parameter int                N_BITS     = 32,
    parameter logic [N_BITS-1:0] RESET_PC   = '0,
    parameter logic [N_BITS-1:0] HALT_INSTR = '1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [N_BITS-1:0] i_redirect_pc,
    output logic              o_imem_req,
    output logic [N_BITS-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [N_BITS-1:0] i_imem_data,
    output logic [N_BITS-1:0] o_instruction,
    output logic [N_BITS-1:0] o_pc_next,
    output logic              o_valid,
    output logic              o_halted
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP, S_HALTED} state_e;

    state_e            state_q;
    logic [N_BITS-1:0] pc_q, pc_d;
    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, rd_ptr_q;
    logic [N_BITS-1:0] instr_q [2];
    logic [N_BITS-1:0] pcn_q   [2];

    logic issue, enq, pop;

    assign issue = i_reset && (state_q == S_IDLE) && i_enable
                   && (count_q != 2'd2) && !i_redirect;
    assign enq   = (state_q == S_WAIT) && i_imem_ack && !i_redirect;
    assign pop   = (count_q != 2'd0) && !i_stall;

    always_comb begin
        count_d = count_q + {1'b0, enq} - {1'b0, pop};
        pc_d    = pc_q;
        if (i_redirect)
            pc_d = i_redirect_pc;
        else if (issue)
            pc_d = pc_q + N_BITS'(4);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (i_redirect) begin
                count_q  <= '0;
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                // A read still in flight must be swallowed unless it completes this very cycle.
                if ((state_q == S_WAIT || state_q == S_DROP) && !i_imem_ack)
                    state_q <= S_DROP;
                else
                    state_q <= S_IDLE;
            end else begin
                count_q <= count_d;
                if (enq) wr_ptr_q <= ~wr_ptr_q;
                if (pop) rd_ptr_q <= ~rd_ptr_q;
                case (state_q)
                    S_IDLE:  if (issue) state_q <= S_WAIT;
                    S_WAIT:  if (i_imem_ack)
                                 state_q <= (i_imem_data == HALT_INSTR) ? S_HALTED : S_IDLE;
                    S_DROP:  if (i_imem_ack) state_q <= S_IDLE;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: buffer payload is not reset; count_q qualifies it and the outputs are masked when empty.
    // pc_q already holds the outstanding request address + 4 while in WAIT.
    always_ff @(posedge i_clock) begin
        if (enq) begin
            instr_q[wr_ptr_q] <= i_imem_data;
            pcn_q[wr_ptr_q]   <= pc_q;
        end
    end

    assign o_imem_req    = issue;
    assign o_imem_addr   = pc_q;
    assign o_valid       = (count_q != 2'd0);
    assign o_instruction = o_valid ? instr_q[rd_ptr_q] : '0;
    assign o_pc_next     = o_valid ? pcn_q[rd_ptr_q]   : '0;
    assign o_halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: an in-bench memory answers requests with a settable latency
// and returns 0x2000_0000 + addr (or the halt word at 0xC when enabled).
module tb_fetch_stage;

    logic        i_clock = 1'b0;
    logic        i_reset, i_enable, i_stall, i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_data;
    logic [31:0] o_instruction, o_pc_next;
    logic        o_valid, o_halted;

    fetch_stage dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_data   (i_imem_data),
        .o_instruction (o_instruction),
        .o_pc_next     (o_pc_next),
        .o_valid       (o_valid),
        .o_halted      (o_halted)
    );

    always #5 i_clock = ~i_clock;

    int          total  = 0;
    int          passed = 0;
    int          lat    = 1;
    bit          halt_en = 1'b0;
    bit          pend_v = 1'b0;
    int          pend_c = 0;
    logic [31:0] pend_a = '0;
    logic [31:0] req_log [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return (halt_en && a == 32'hC) ? 32'hFFFF_FFFF : 32'h2000_0000 + a;
    endfunction

    // One clock cycle: log any request seen with the current inputs, then present the
    // memory's ack for the following cycle.
    task automatic step();
        #1;
        if (o_imem_req) begin
            req_log.push_back(o_imem_addr);
            pend_v = 1'b1;
            pend_a = o_imem_addr;
            pend_c = lat;
        end
        @(posedge i_clock);
        #1;
        i_imem_ack = 1'b0;
        if (pend_v) begin
            pend_c--;
            if (pend_c == 0) begin
                i_imem_ack  = 1'b1;
                i_imem_data = word(pend_a);
                pend_v      = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        i_reset    = 1'b0;
        i_enable   = 1'b0;
        i_stall    = 1'b0;
        i_redirect = 1'b0;
        run(2);
        req_log.delete();
        i_reset = 1'b1;
    endtask

    initial begin
        i_reset       = 1'b0;
        i_enable      = 1'b0;
        i_stall       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_imem_ack    = 1'b0;
        i_imem_data   = '0;
        @(posedge i_clock);
        #1;

        // Reset state and in-order streaming with latency 1
        do_reset();
        i_reset = 1'b0;
        #1;
        check("rst_req",    {31'd0, o_imem_req}, 32'd0);
        check("rst_valid",  {31'd0, o_valid},    32'd0);
        check("rst_halted", {31'd0, o_halted},   32'd0);
        check("rst_instr",  o_instruction,       32'd0);
        check("rst_pcnext", o_pc_next,           32'd0);
        i_reset  = 1'b1;
        i_enable = 1'b1;
        lat      = 1;
        step();
        check("first_req_cnt",  32'(req_log.size()), 32'd1);
        check("first_req_addr", req_log[0],          32'h0);
        step();
        check("s1_valid",  {31'd0, o_valid}, 32'd1);
        check("s1_instr",  o_instruction,    32'h2000_0000);
        check("s1_pcnext", o_pc_next,        32'h4);
        step();
        check("req2_addr", req_log[1],       32'h4);
        check("s2_empty",  {31'd0, o_valid}, 32'd0);
        step();
        check("s2_instr",  o_instruction, 32'h2000_0004);
        check("s2_pcnext", o_pc_next,     32'h8);
        step();
        check("req3_addr", req_log[2], 32'h8);

        // Stall: buffer fills to two entries and fetch stops
        i_stall = 1'b1;
        run(9);
        check("stall_req_cnt", 32'(req_log.size()), 32'd4);
        check("stall_valid",   {31'd0, o_valid},    32'd1);
        check("stall_instr",   o_instruction,       32'h2000_0008);
        check("stall_pcnext",  o_pc_next,           32'hC);
        i_stall = 1'b0;
        step();
        check("drain1_instr",  o_instruction, 32'h2000_000C);
        check("drain1_pcnext", o_pc_next,     32'h10);
        step();
        check("drain2_empty",   {31'd0, o_valid},    32'd0);
        check("drain2_req_cnt", 32'(req_log.size()), 32'd5);
        check("drain2_req",     req_log[4],          32'h10);
        step();
        check("drain3_instr",  o_instruction, 32'h2000_0010);
        check("drain3_pcnext", o_pc_next,     32'h14);

        // Redirect while a latency-3 read of 0x8 is outstanding
        do_reset();
        i_enable = 1'b1;
        lat      = 1;
        run(4);
        lat     = 3;
        i_stall = 1'b1;
        step();
        check("redir_req8",    req_log[2],       32'h8);
        check("redir_pre_vld", {31'd0, o_valid}, 32'd1);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h100;
        step();
        check("redir_flush_vld", {31'd0, o_valid}, 32'd0);
        i_redirect = 1'b0;
        run(2);
        check("drop_no_req", 32'(req_log.size()), 32'd3);
        check("drop_no_enq", {31'd0, o_valid},    32'd0);
        lat = 1;
        step();
        check("redir_req_cnt",  32'(req_log.size()), 32'd4);
        check("redir_req_addr", req_log[3],          32'h100);
        step();
        check("redir_instr",  o_instruction, 32'h2000_0100);
        check("redir_pcnext", o_pc_next,     32'h104);

        // Redirect coinciding with the ack
        step();
        check("coinc_req", req_log[$], 32'h104);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h200;
        step();
        check("coinc_flush_vld", {31'd0, o_valid}, 32'd0);
        i_redirect = 1'b0;
        step();
        check("coinc_next_req", req_log[$], 32'h200);
        step();
        check("coinc_instr",  o_instruction, 32'h2000_0200);
        check("coinc_pcnext", o_pc_next,     32'h204);

        // Halt word at 0xC, then redirect to 0x40
        do_reset();
        i_enable = 1'b1;
        lat      = 1;
        halt_en  = 1'b1;
        run(8);
        check("halt_flag",    {31'd0, o_halted}, 32'd1);
        check("halt_valid",   {31'd0, o_valid},  32'd1);
        check("halt_instr",   o_instruction,     32'hFFFF_FFFF);
        check("halt_pcnext",  o_pc_next,         32'h10);
        check("halt_req_cnt", 32'(req_log.size()), 32'd4);
        run(5);
        check("halted_no_req", 32'(req_log.size()), 32'd4);
        check("halted_stays",  {31'd0, o_halted},   32'd1);
        check("halted_drain",  {31'd0, o_valid},    32'd0);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h40;
        step();
        check("unhalt_flag", {31'd0, o_halted}, 32'd0);
        i_redirect = 1'b0;
        step();
        check("unhalt_req", req_log[$], 32'h40);
        step();
        check("unhalt_instr",  o_instruction, 32'h2000_0040);
        check("unhalt_pcnext", o_pc_next,     32'h44);
        halt_en = 1'b0;

        // Reset with a read outstanding and data buffered; the late ack must be ignored
        do_reset();
        i_enable = 1'b1;
        i_stall  = 1'b1;
        lat      = 1;
        run(2);
        lat = 3;
        step();
        check("mid_pre_valid", {31'd0, o_valid}, 32'd1);
        check("mid_pre_req",   req_log[$],       32'h4);
        i_reset = 1'b0;
        step();
        check("mid_rst_req",    {31'd0, o_imem_req}, 32'd0);
        check("mid_rst_valid",  {31'd0, o_valid},    32'd0);
        check("mid_rst_halted", {31'd0, o_halted},   32'd0);
        check("mid_rst_instr",  o_instruction,       32'd0);
        check("mid_rst_pcnext", o_pc_next,           32'd0);
        i_reset  = 1'b1;
        i_enable = 1'b0;
        run(2);
        check("stale_ack_vld", {31'd0, o_valid},    32'd0);
        check("stale_no_req",  32'(req_log.size()), 32'd2);
        i_enable = 1'b1;
        lat      = 1;
        step();
        check("post_rst_req_cnt", 32'(req_log.size()), 32'd3);
        check("post_rst_req",     req_log[$],          32'h0);
        step();
        check("post_rst_instr",  o_instruction, 32'h2000_0000);
        check("post_rst_pcnext", o_pc_next,     32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
